// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences one RV32I instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB for the shared-memory multi-cycle datapath.
// Control outputs are decoded from the registered state and latched class.
// The handshake-dependent strobes also use the current inputs: ir_write and
// the store's pc_write follow mem_ready, and a branch's pc_src follows
// branch_taken. Illegal opcodes and memory timeouts park the FSM in TRAP.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 0,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [1:0]       aluop,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_L, CL_S, CL_B, CL_JAL, CL_JALR
    } class_t;

    // Wait counter only has to reach MEM_TIMEOUT-1; the timeout fires on the
    // edge that would have taken it to MEM_TIMEOUT.
    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] TO_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state;
    class_t           r_cls;
    logic [WCW-1:0]   r_wait;
    logic             r_trap;
    logic             r_cause;
    logic [CNT_W-1:0] r_instret;

    class_t w_cls;
    logic   w_legal;
    logic   w_timeout;

    // Opcode classification; jumps are only legal when enabled.
    always_comb begin
        w_cls   = CL_R;
        w_legal = 1'b1;
        case (opcode)
            7'b0110011: w_cls = CL_R;
            7'b0010011: w_cls = CL_I;
            7'b0000011: w_cls = CL_L;
            7'b0100011: w_cls = CL_S;
            7'b1100011: w_cls = CL_B;
            7'b1101111: begin w_cls = CL_JAL;  w_legal = ENABLE_JUMP; end
            7'b1100111: begin w_cls = CL_JALR; w_legal = ENABLE_JUMP; end
            default:    w_legal = 1'b0;
        endcase
    end

    // A ready on the final allowed wait cycle still completes the access.
    assign w_timeout = (MEM_TIMEOUT > 0) && !mem_ready && (r_wait == TO_LAST);

    // State sequencing, class latch, wait counter, sticky trap and instret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cls     <= CL_R;
            r_wait    <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 1'b0;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        if (r_state == S_FETCH) begin
                            r_state <= S_DECODE;
                        end else if (r_cls == CL_L) begin
                            r_state <= S_WB;
                        end else begin
                            r_state   <= S_FETCH;
                            r_wait    <= '0;
                            r_instret <= r_instret + CNT_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 1'b1;
                    end else if (MEM_TIMEOUT > 0) begin
                        r_wait <= r_wait + WCW'(1);
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_cls   <= w_cls;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (r_cls == CL_B) begin
                        r_state   <= S_FETCH;
                        r_wait    <= '0;
                        r_instret <= r_instret + CNT_W'(1);
                    end else if (r_cls == CL_L || r_cls == CL_S) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_state   <= S_FETCH;
                    r_wait    <= '0;
                    r_instret <= r_instret + CNT_W'(1);
                end
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Datapath controls decoded from state and latched class.
    always_comb begin
        mem_req   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_iord  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src   = 1'b0;
        aluop     = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_re   = 1'b1;
                ir_write = mem_ready;
            end
            S_EXEC: begin
                case (r_cls)
                    CL_R:    aluop = 2'b10;
                    CL_I:    begin alu_src = 1'b1; aluop = 2'b10; end
                    CL_L,
                    CL_S,
                    CL_JALR: alu_src = 1'b1;
                    CL_B: begin
                        aluop    = 2'b01;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_iord = 1'b1;
                alu_src  = 1'b1;
                mem_re   = (r_cls == CL_L);
                mem_we   = (r_cls == CL_S);
                pc_write = (r_cls == CL_S) && mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (r_cls)
                    CL_L:    wb_sel = 2'b01;
                    CL_JAL:  begin wb_sel = 2'b10; pc_src = 2'b01; end
                    CL_JALR: begin wb_sel = 2'b10; pc_src = 2'b10; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three instances (default, jumps disabled,
// 4-cycle timeout with a 3-bit instret) share stimulus; one is checked at a time
// against an instruction-level model of the expected per-cycle controls.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;

    logic [2:0]       mem_req, mem_re, mem_we, mem_iord, ir_write, pc_write;
    logic [2:0]       alu_src, reg_write, trap, trap_cause;
    logic [2:0][1:0]  pc_src, aluop, wb_sel;
    logic [31:0]      ir0, ir1;
    logic [2:0]       ir2;

    int   nassert = 0;
    int   nfail = 0;
    int   sel = 0;
    int   n_ret = 0;
    logic exp_trap = 1'b0;
    logic exp_cause = 1'b0;

    typedef enum int {K_R, K_I, K_L, K_S, K_B, K_JAL, K_JALR} kind_t;

    always #5 clk = ~clk;

    multicycle_control_unit dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req[0]), .mem_re(mem_re[0]),
        .mem_we(mem_we[0]), .mem_iord(mem_iord[0]), .ir_write(ir_write[0]),
        .pc_write(pc_write[0]), .pc_src(pc_src[0]), .alu_src(alu_src[0]),
        .aluop(aluop[0]), .reg_write(reg_write[0]), .wb_sel(wb_sel[0]),
        .trap(trap[0]), .trap_cause(trap_cause[0]), .instret(ir0)
    );

    multicycle_control_unit #(.ENABLE_JUMP(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req[1]), .mem_re(mem_re[1]),
        .mem_we(mem_we[1]), .mem_iord(mem_iord[1]), .ir_write(ir_write[1]),
        .pc_write(pc_write[1]), .pc_src(pc_src[1]), .alu_src(alu_src[1]),
        .aluop(aluop[1]), .reg_write(reg_write[1]), .wb_sel(wb_sel[1]),
        .trap(trap[1]), .trap_cause(trap_cause[1]), .instret(ir1)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req[2]), .mem_re(mem_re[2]),
        .mem_we(mem_we[2]), .mem_iord(mem_iord[2]), .ir_write(ir_write[2]),
        .pc_write(pc_write[2]), .pc_src(pc_src[2]), .alu_src(alu_src[2]),
        .aluop(aluop[2]), .reg_write(reg_write[2]), .wb_sel(wb_sel[2]),
        .trap(trap[2]), .trap_cause(trap_cause[2]), .instret(ir2)
    );

    // Control vector order: req re we iord irw pcw pcsrc alusrc aluop regw wbsel
    function automatic logic [13:0] ctl(input logic req, re, we, iord, irw, pcw,
                                        input logic [1:0] pcs, input logic as,
                                        input logic [1:0] aop, input logic rw,
                                        input logic [1:0] wbs);
        return {req, re, we, iord, irw, pcw, pcs, as, aop, rw, wbs};
    endfunction

    function automatic logic [13:0] act_ctl(input int d);
        return {mem_req[d], mem_re[d], mem_we[d], mem_iord[d], ir_write[d], pc_write[d],
                pc_src[d], alu_src[d], aluop[d], reg_write[d], wb_sel[d]};
    endfunction

    function automatic logic [31:0] act_ret(input int d);
        if (d == 0) return ir0;
        if (d == 1) return ir1;
        return {29'd0, ir2};
    endfunction

    function automatic logic [6:0] opc(input kind_t k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_L:     return 7'b0000011;
            K_S:     return 7'b0100011;
            K_B:     return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    task automatic check(input string tag, input logic [13:0] e);
        logic [31:0] er;
        er = (sel == 2) ? 32'(n_ret % 8) : 32'(n_ret);
        nassert++;
        assert (act_ctl(sel) === e) else begin
            nfail++;
            $error("FAIL %s ctl: got %b expected %b", tag, act_ctl(sel), e);
        end
        nassert++;
        assert ({trap[sel], trap_cause[sel] & exp_trap} === {exp_trap, exp_cause & exp_trap}) else begin
            nfail++;
            $error("FAIL %s trap/cause: got %b%b expected %b%b", tag, trap[sel],
                   trap_cause[sel], exp_trap, exp_cause);
        end
        nassert++;
        assert (act_ret(sel) === er) else begin
            nfail++;
            $error("FAIL %s instret: got %0d expected %0d", tag, act_ret(sel), er);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later.
    task automatic cyc(input logic [13:0] e, input logic rdy, input logic br,
                       input logic [6:0] op, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        branch_taken = br;
        opcode = op;
        #1;
        check(tag, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        n_ret = 0;
        exp_trap = 1'b0;
        exp_cause = 1'b0;
        #1 check("reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle", '0);
    endtask

    // Expected controls derived from the instruction class rules.
    function automatic logic [13:0] exec_ctl(input kind_t k, input logic br);
        case (k)
            K_R:     return ctl(0,0,0,0,0,0,2'b00,0,2'b10,0,2'b00);
            K_I:     return ctl(0,0,0,0,0,0,2'b00,1,2'b10,0,2'b00);
            K_L, K_S, K_JALR:
                     return ctl(0,0,0,0,0,0,2'b00,1,2'b00,0,2'b00);
            K_B:     return ctl(0,0,0,0,0,1,br ? 2'b01 : 2'b00,0,2'b01,0,2'b00);
            default: return '0;
        endcase
    endfunction

    function automatic logic [13:0] wb_ctl(input kind_t k);
        case (k)
            K_L:     return ctl(0,0,0,0,0,1,2'b00,0,2'b00,1,2'b01);
            K_JAL:   return ctl(0,0,0,0,0,1,2'b01,0,2'b00,1,2'b10);
            K_JALR:  return ctl(0,0,0,0,0,1,2'b10,0,2'b00,1,2'b10);
            default: return ctl(0,0,0,0,0,1,2'b00,0,2'b00,1,2'b00);
        endcase
    endfunction

    function automatic logic [13:0] mem_ctl(input kind_t k, input logic rdy);
        return ctl(1, k == K_L, k == K_S, 1, 0, (k == K_S) && rdy, 2'b00, 1, 2'b00, 0, 2'b00);
    endfunction

    localparam logic [13:0] FETCH_WAIT = 14'b11000000000000;
    localparam logic [13:0] FETCH_DONE = 14'b11001000000000;

    task automatic run_instr(input kind_t k, input logic br, input int fw, input int mw);
        string t;
        t = k.name();
        for (int i = 0; i < fw; i++) cyc(FETCH_WAIT, 1'b0, 1'($urandom), junk(), {t, " fetch-wait"});
        cyc(FETCH_DONE, 1'b1, 1'($urandom), junk(), {t, " fetch"});
        cyc('0, 1'($urandom), 1'($urandom), opc(k), {t, " decode"});
        cyc(exec_ctl(k, br), 1'($urandom), br, junk(), {t, " exec"});
        if (k == K_B) begin
            n_ret++;
            return;
        end
        if (k == K_L || k == K_S) begin
            for (int i = 0; i < mw; i++) cyc(mem_ctl(k, 1'b0), 1'b0, 1'($urandom), junk(), {t, " mem-wait"});
            cyc(mem_ctl(k, 1'b1), 1'b1, 1'($urandom), junk(), {t, " mem"});
            if (k == K_S) begin
                n_ret++;
                return;
            end
        end
        cyc(wb_ctl(k), 1'($urandom), 1'($urandom), junk(), {t, " wb"});
        n_ret++;
    endtask

    task automatic trap_hold(input string tag);
        for (int i = 0; i < 3; i++) cyc('0, 1'($urandom), 1'($urandom), junk(), tag);
    endtask

    initial begin
        // Default instance: directed instructions.
        sel = 0;
        do_reset();
        run_instr(K_R, 1'b0, 0, 0);
        run_instr(K_L, 1'b0, 0, 2);
        run_instr(K_B, 1'b1, 0, 0);
        run_instr(K_B, 1'b0, 0, 0);
        run_instr(K_JALR, 1'b0, 0, 0);
        run_instr(K_JAL, 1'b0, 1, 0);
        run_instr(K_I, 1'b0, 2, 0);
        run_instr(K_S, 1'b0, 0, 1);
        // Randomized instruction stream.
        for (int n = 0; n < 40; n++)
            run_instr(kind_t'($urandom_range(0, 6)), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        // Illegal opcode traps with cause 0 and freezes instret.
        cyc(FETCH_DONE, 1'b1, 1'b0, junk(), "illegal fetch");
        cyc('0, 1'b1, 1'b0, 7'b0000000, "illegal decode");
        exp_trap = 1'b1;
        exp_cause = 1'b0;
        trap_hold("illegal trap");

        // Reset asserted while a store waits in MEM.
        do_reset();
        cyc(FETCH_DONE, 1'b1, 1'b0, junk(), "sw fetch");
        cyc('0, 1'b1, 1'b0, opc(K_S), "sw decode");
        cyc(exec_ctl(K_S, 1'b0), 1'b0, 1'b0, junk(), "sw exec");
        cyc(mem_ctl(K_S, 1'b0), 1'b0, 1'b0, junk(), "sw mem");
        #2 rst_n = 1'b0;
        #1 check("sw async reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("sw idle", '0);
        cyc(FETCH_WAIT, 1'b0, 1'b0, junk(), "sw refetch");

        // Jumps disabled: JALR traps after DECODE.
        sel = 1;
        do_reset();
        run_instr(K_R, 1'b0, 0, 0);
        cyc(FETCH_DONE, 1'b1, 1'b0, junk(), "nojump fetch");
        cyc('0, 1'b1, 1'b0, opc(K_JALR), "nojump decode");
        exp_trap = 1'b1;
        exp_cause = 1'b0;
        trap_hold("nojump trap");

        // Timeout instance: four unready fetch cycles trap.
        sel = 2;
        do_reset();
        for (int i = 0; i < 4; i++) cyc(FETCH_WAIT, 1'b0, 1'b0, junk(), "to fetch-wait");
        exp_trap = 1'b1;
        exp_cause = 1'b1;
        trap_hold("to fetch trap");
        // Ready on the fourth cycle completes normally; then wrap the 3-bit counter.
        do_reset();
        run_instr(K_R, 1'b0, 3, 0);
        for (int n = 0; n < 11; n++)
            run_instr(kind_t'($urandom_range(0, 6)), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        // Load that never gets ready in MEM.
        cyc(FETCH_DONE, 1'b1, 1'b0, junk(), "to lw fetch");
        cyc('0, 1'b1, 1'b0, opc(K_L), "to lw decode");
        cyc(exec_ctl(K_L, 1'b0), 1'b0, 1'b0, junk(), "to lw exec");
        for (int i = 0; i < 4; i++) cyc(mem_ctl(K_L, 1'b0), 1'b0, 1'b0, junk(), "to lw mem-wait");
        exp_trap = 1'b1;
        exp_cause = 1'b1;
        trap_hold("to mem trap");

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
